fast_ring_bank: RTL and testbench
=================================

// Module: fast_ring_bank
// PURPOSE
//  Double-buffered, parametrised register bank feeding the FAST corner comparator.
//  - Host writes one candidate window into the fill bank: reference pixel, RING_N circle pixels, threshold.
//  - A commit moves a complete window into the output bank and presents it with a valid/ready handshake.
//  - The next window loads while the comparator consumes the current one.
// PARAMETERS
//  PIX_W        8    pixel / threshold width in bits
//  RING_N       16   circle pixels per window (12..32)
//  ADDR_W       6    write-address width; must satisfy 2^ADDR_W >= RING_N+2
//  THR_DEFAULT  50   threshold register value after reset
// PORTS
//  clk        in   1              clock
//  nRESET     in   1              reset, asynchronous, active-low
//  wr_en      in   1              write strobe
//  wr_addr    in   ADDR_W         0=ref, 1..RING_N=ring[addr-1], RING_N+1=threshold
//  wr_data    in   PIX_W          write data
//  wr_commit  in   1              request transfer of fill bank to output bank
//  load_ready out  1              1 = fill bank accepts writes/commit (state FILL)
//  err        out  1              1-cycle pulse on rejected write or commit
//  out_valid  out  1              output bank holds an unconsumed window
//  out_ready  in   1              comparator accepts window when out_valid=1
//  out_ref    out  PIX_W          reference pixel
//  out_ring   out  RING_N*PIX_W   ring[i] at bits [i*PIX_W +: PIX_W]
//  out_thr    out  PIX_W          threshold captured at commit
// BEHAVIOUR
//  Reset values:
//  - all pixel regs 0; thr reg THR_DEFAULT; written-mask 0; state FILL.
//  - out_valid 0, out_* 0, out_thr THR_DEFAULT, err 0, load_ready 1.
//  Written-mask:
//  - RING_N+1 bits (ref + ring); set by accepted writes to addr 0..RING_N.
//  - Threshold is sticky config: not in the mask, kept across windows, writable only in FILL.
//  Write in FILL:
//  - Takes effect next edge; rewriting an address overwrites it, no error.
//  - addr > RING_N+1 -> ignored, err pulse.
//  - Any write while PENDING -> ignored, err pulse.
//  Commit in FILL (mask evaluated including a same-cycle write):
//  - Mask incomplete -> no transfer, mask kept, err pulse, stay FILL.
//  - Complete and output free (out_valid=0, or out_valid&out_ready) -> copy fill->output next edge.
//    out_valid=1 at t+1 (1-cycle latency); mask cleared; stay FILL.
//  - Complete and output busy -> go PENDING; load_ready=0.
//  PENDING -> FILL:
//  - First cycle out_ready=1: transfer, out_valid stays 1 (back-to-back), mask cleared.
//  - Commit while PENDING: ignored, no err.
//  Output handshake:
//  - out_valid&out_ready with nothing to transfer -> out_valid 0 next edge.
//  - out_* held stable while out_valid=1 and not consumed; unchanged after consumption.
//  - out_ready while out_valid=0 has no effect.
//  Priority same cycle: write, then commit evaluation, then consume.
//  nRESET asserted mid-load or mid-handshake: everything returns to reset values immediately; partial window lost.
//  No arithmetic; all transfers are full-width copies.
// STRUCTURE
//  fast_pkg (shared):
//  - ADDR_REF=0, ADDR_RING0=1, addr_thr(RING_N)=RING_N+1, THR_DEFAULT.
//  - State enum {FILL, PENDING}; clog2 function.
//  One sub-module, fast_wr_decode:
//  - combinational wr_addr -> one-hot enable (RING_N+2 bits) plus out_of_range flag.
//  Banks, mask, FSM and handshake in this module.
// TESTING
//  1 Reset -> out_valid 0, load_ready 1, out_thr 50, out_ref 0.
//  2 Write ref=0x80, ring[i]=i+1, thr=20, commit, out_ready=0
//    -> out_valid=1 next cycle; out_ref 0x80, ring[15]=16, out_thr 20.
//  3 Commit with ring[7] never written -> err 1 cycle, out_valid stays 0;
//    write ring[7], commit -> valid.
//  4 Window A held (out_ready=0), fill + commit B -> load_ready 0, write err;
//    raise out_ready -> B presented next cycle, out_valid never drops.
//  5 wr_addr=RING_N+2 -> err pulse, no register changes.
//  6 nRESET low while PENDING -> all outputs reset values, state FILL.

Source files
------------

// File: rtl/fast_pkg.sv
// Shared constants, state encoding and helpers for the FAST ring register bank.
package fast_pkg;

  localparam int unsigned ADDR_REF    = 0;
  localparam int unsigned ADDR_RING0  = 1;
  localparam int unsigned THR_DEFAULT = 50;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_e;

  // Threshold sits directly after the last ring pixel.
  function automatic int unsigned addr_thr(input int unsigned ring_n);
    return ring_n + 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/fast_wr_decode.sv
// Write-address decode: one-hot register select plus out-of-range flag.
module fast_wr_decode
  import fast_pkg::*;
#(
  parameter int unsigned RING_N = 16,
  parameter int unsigned ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] wr_addr,
  output logic [RING_N+1:0] sel_c,
  output logic              oor_c
);

  always_comb begin
    sel_c = '0;
    for (int unsigned i = 0; i < RING_N + 2; i++) begin
      sel_c[i] = (wr_addr == ADDR_W'(i));
    end
    oor_c = (wr_addr > ADDR_W'(addr_thr(RING_N)));
  end

endmodule

// File: rtl/fast_ring_bank.sv
// Double-buffered window bank: host fills one bank while the comparator
// consumes the other through a valid/ready handshake.
module fast_ring_bank
  import fast_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned RING_N      = 16,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned THR_DEFAULT = fast_pkg::THR_DEFAULT
) (
  input  logic                      clk,
  input  logic                      nRESET,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [PIX_W-1:0]          wr_data,
  input  logic                      wr_commit,
  output logic                      load_ready,
  output logic                      err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PIX_W-1:0]          out_ref,
  output logic [RING_N*PIX_W-1:0]   out_ring,
  output logic [PIX_W-1:0]          out_thr
);

  localparam int unsigned SEL_W   = RING_N + 2;
  localparam int unsigned MASK_W  = RING_N + 1;
  localparam int unsigned RING_W  = RING_N * PIX_W;
  localparam int unsigned THR_IDX = addr_thr(RING_N);

  logic [SEL_W-1:0]  sel_c;
  logic              oor_c;

  state_e            state, state_nx;
  logic [PIX_W-1:0]  fill_ref, fill_ref_nx;
  logic [PIX_W-1:0]  fill_thr, fill_thr_nx;
  logic [RING_W-1:0] fill_ring, fill_ring_nx;
  logic [MASK_W-1:0] mask, mask_nx, mask_wr_c;
  logic              wr_ok_c, xfer_c, valid_nx, err_nx;

  fast_wr_decode #(
    .RING_N (RING_N),
    .ADDR_W (ADDR_W)
  ) u_wr_decode (
    .wr_addr (wr_addr),
    .sel_c   (sel_c),
    .oor_c   (oor_c)
  );

  // Fill-bank view including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    wr_ok_c      = wr_en && !oor_c && (state == FILL);
    fill_ref_nx  = fill_ref;
    fill_ring_nx = fill_ring;
    fill_thr_nx  = fill_thr;
    mask_wr_c    = mask;
    if (wr_ok_c) begin
      if (sel_c[ADDR_REF]) fill_ref_nx = wr_data;
      for (int unsigned i = 0; i < RING_N; i++) begin
        if (sel_c[ADDR_RING0 + i]) fill_ring_nx[i*PIX_W +: PIX_W] = wr_data;
      end
      if (sel_c[THR_IDX]) fill_thr_nx = wr_data;
      mask_wr_c = mask | sel_c[MASK_W-1:0];
    end
  end

  // Commit / transfer / consume decision.
  always_comb begin
    state_nx = state;
    mask_nx  = mask_wr_c;
    xfer_c   = 1'b0;
    valid_nx = out_valid;
    err_nx   = wr_en && (oor_c || (state == PENDING));
    case (state)
      FILL: begin
        if (wr_commit) begin
          if (!(&mask_wr_c)) begin
            err_nx = 1'b1;
          end else if (!out_valid || out_ready) begin
            xfer_c  = 1'b1;
            mask_nx = '0;
          end else begin
            state_nx = PENDING;
          end
        end
      end
      PENDING: begin
        if (out_ready) begin
          xfer_c   = 1'b1;
          mask_nx  = '0;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
    if (xfer_c) begin
      valid_nx = 1'b1;
    end else if (out_valid && out_ready) begin
      valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state <= FILL;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      fill_ref   <= '0;
      fill_ring  <= '0;
      fill_thr   <= PIX_W'(THR_DEFAULT);
      mask       <= '0;
      out_valid  <= 1'b0;
      out_ref    <= '0;
      out_ring   <= '0;
      out_thr    <= PIX_W'(THR_DEFAULT);
      err        <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      fill_ref   <= fill_ref_nx;
      fill_ring  <= fill_ring_nx;
      fill_thr   <= fill_thr_nx;
      mask       <= mask_nx;
      out_valid  <= valid_nx;
      err        <= err_nx;
      load_ready <= (state_nx == FILL);
      if (xfer_c) begin
        out_ref  <= fill_ref_nx;
        out_ring <= fill_ring_nx;
        out_thr  <= fill_thr_nx;
      end
    end
  end

endmodule

// File: tb/tb_fast_ring_bank.sv
// Bench for fast_ring_bank: directed scenarios plus random traffic against a window-level model.
module tb_fast_ring_bank;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned RING_N = 16;
  localparam int unsigned ADDR_W = 6;

  logic                    clk;
  logic                    nRESET;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [PIX_W-1:0]        wr_data;
  logic                    wr_commit;
  logic                    load_ready;
  logic                    err;
  logic                    out_valid;
  logic                    out_ready;
  logic [PIX_W-1:0]        out_ref;
  logic [RING_N*PIX_W-1:0] out_ring;
  logic [PIX_W-1:0]        out_thr;

  int errors = 0;
  int checks = 0;

  fast_ring_bank #(
    .PIX_W       (PIX_W),
    .RING_N      (RING_N),
    .ADDR_W      (ADDR_W),
    .THR_DEFAULT (50)
  ) dut (
    .clk        (clk),
    .nRESET     (nRESET),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .load_ready (load_ready),
    .err        (err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ref    (out_ref),
    .out_ring   (out_ring),
    .out_thr    (out_thr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Window-level reference model
  logic [7:0] m_ref, m_thr, m_oref, m_othr;
  logic [7:0] m_ring [RING_N];
  logic [7:0] m_oring [RING_N];
  bit         m_wr [RING_N+1];
  bit         m_pend, m_valid, m_err;

  function automatic void model_reset();
    m_ref = 0; m_thr = 50; m_oref = 0; m_othr = 50;
    foreach (m_ring[i]) begin m_ring[i] = 0; m_oring[i] = 0; end
    foreach (m_wr[i]) m_wr[i] = 0;
    m_pend = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit we, input int a, input logic [7:0] d,
                                     input bit cm, input bit rdy);
    bit present, all;
    present = 0;
    m_err = 0;
    if (we) begin
      if (m_pend || a > RING_N + 1) m_err = 1;
      else if (a == 0) begin m_ref = d; m_wr[0] = 1; end
      else if (a <= RING_N) begin m_ring[a-1] = d; m_wr[a] = 1; end
      else m_thr = d;
    end
    all = 1;
    foreach (m_wr[i]) if (!m_wr[i]) all = 0;
    if (m_pend) begin
      if (rdy) begin present = 1; m_pend = 0; end
    end else if (cm) begin
      if (!all) m_err = 1;
      else if (!m_valid || rdy) present = 1;
      else m_pend = 1;
    end
    if (present) begin
      m_oref = m_ref; m_othr = m_thr;
      foreach (m_ring[i]) m_oring[i] = m_ring[i];
      foreach (m_wr[i]) m_wr[i] = 0;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  function automatic logic [RING_N*PIX_W-1:0] m_ring_vec();
    logic [RING_N*PIX_W-1:0] v;
    for (int i = 0; i < RING_N; i++) v[i*PIX_W +: PIX_W] = m_oring[i];
    return v;
  endfunction

  // Drive one cycle of inputs, advance model with the edge, sample 1 time unit later.
  task automatic cycle(input bit we, input int a, input logic [7:0] d, input bit cm, input bit rdy);
    wr_en = we; wr_addr = ADDR_W'(a); wr_data = d; wr_commit = cm; out_ready = rdy;
    @(posedge clk);
    model_step(we, a, d, cm, rdy);
    #1;
    wr_en = 0; wr_commit = 0; out_ready = 0;
  endtask

  task automatic fill_all(input logic [7:0] r, input logic [7:0] off, input int skip);
    cycle(1, 0, r, 0, 0);
    for (int i = 0; i < RING_N; i++) if (i != skip) cycle(1, i + 1, 8'(off + 8'(i)), 0, 0);
  endtask

  task automatic test_reset();
    nRESET = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got=%0b exp=1", load_ready); end
    checks++; if (out_thr !== 8'd50) begin errors++; $display("FAIL reset_thr got=%0d exp=50", out_thr); end
    checks++; if (out_ref !== 8'd0) begin errors++; $display("FAIL reset_ref got=%0d exp=0", out_ref); end
    checks++; if (out_ring !== '0) begin errors++; $display("FAIL reset_ring got=%h exp=0", out_ring); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b exp=0", err); end
    model_reset();
    @(negedge clk) nRESET = 1;
  endtask

  task automatic test_basic_window();
    fill_all(8'h80, 8'd1, -1);
    cycle(1, RING_N + 1, 8'd20, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pre_valid got=%0b exp=0", out_valid); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b exp=1", out_valid); end
    checks++; if (out_ref !== 8'h80) begin errors++; $display("FAIL basic_ref got=%h exp=80", out_ref); end
    checks++; if (out_ring[15*PIX_W +: PIX_W] !== 8'd16) begin errors++; $display("FAIL basic_ring15 got=%0d exp=16", out_ring[15*PIX_W +: PIX_W]); end
    checks++; if (out_ring[0 +: PIX_W] !== 8'd1) begin errors++; $display("FAIL basic_ring0 got=%0d exp=1", out_ring[0 +: PIX_W]); end
    checks++; if (out_thr !== 8'd20) begin errors++; $display("FAIL basic_thr got=%0d exp=20", out_thr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got=%0b exp=0", err); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_ref !== 8'h80) begin errors++; $display("FAIL basic_hold got=%0b/%h exp=1/80", out_valid, out_ref); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consume got=%0b exp=0", out_valid); end
    checks++; if (out_ref !== 8'h80) begin errors++; $display("FAIL basic_after_consume_ref got=%h exp=80", out_ref); end
  endtask

  task automatic test_incomplete();
    fill_all(8'h33, 8'h10, 7);
    cycle(0, 0, 0, 1, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL incomplete_err got=%0b exp=1", err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL incomplete_valid got=%0b exp=0", out_valid); end
    cycle(0, 0, 0, 0, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL incomplete_err_pulse got=%0b exp=0", err); end
    cycle(1, 8, 8'hA7, 1, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL incomplete_fix_valid got=%0b exp=1", out_valid); end
    checks++; if (out_ring[7*PIX_W +: PIX_W] !== 8'hA7) begin errors++; $display("FAIL incomplete_ring7 got=%h exp=a7", out_ring[7*PIX_W +: PIX_W]); end
    checks++; if (out_ring[8*PIX_W +: PIX_W] !== 8'h18) begin errors++; $display("FAIL incomplete_ring8 got=%h exp=18", out_ring[8*PIX_W +: PIX_W]); end
    checks++; if (out_thr !== 8'd20) begin errors++; $display("FAIL incomplete_thr_sticky got=%0d exp=20", out_thr); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL incomplete_fix_err got=%0b exp=0", err); end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    fill_all(8'hA0, 8'h20, -1);
    cycle(0, 0, 0, 1, 0);
    fill_all(8'hB0, 8'h60, -1);
    checks++; if (out_ref !== 8'hA0 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_a got=%0b/%h exp=1/a0", out_valid, out_ref); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_pending_lr got=%0b exp=0", load_ready); end
    checks++; if (out_ref !== 8'hA0) begin errors++; $display("FAIL b2b_pending_ref got=%h exp=a0", out_ref); end
    cycle(1, 0, 8'hEE, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL b2b_write_err got=%0b exp=1", err); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_commit_noerr got=%0b exp=0", err); end
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_pending got=%0b exp=0", load_ready); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_kept got=%0b exp=1", out_valid); end
    checks++; if (out_ref !== 8'hB0) begin errors++; $display("FAIL b2b_ref_b got=%h exp=b0", out_ref); end
    checks++; if (out_ring[3*PIX_W +: PIX_W] !== 8'h63) begin errors++; $display("FAIL b2b_ring3 got=%h exp=63", out_ring[3*PIX_W +: PIX_W]); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL b2b_lr_back got=%0b exp=1", load_ready); end
    cycle(0, 0, 0, 0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_bad_addr();
    cycle(1, RING_N + 2, 8'hAA, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_addr_err got=%0b exp=1", err); end
    checks++; if (out_valid !== 1'b0 || load_ready !== 1'b1) begin errors++; $display("FAIL bad_addr_state got=%0b/%0b exp=0/1", out_valid, load_ready); end
    cycle(1, 63, 8'h55, 0, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_addr63_err got=%0b exp=1", err); end
    cycle(0, 0, 0, 1, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_addr_mask_empty got=%0b exp=1", err); end
    fill_all(8'h11, 8'h40, -1);
    cycle(0, 0, 0, 1, 0);
    checks++; if (out_thr !== 8'd20) begin errors++; $display("FAIL bad_addr_thr got=%0d exp=20", out_thr); end
    checks++; if (out_ref !== 8'h11) begin errors++; $display("FAIL bad_addr_ref got=%h exp=11", out_ref); end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_pending();
    fill_all(8'h01, 8'h02, -1);
    cycle(0, 0, 0, 1, 0);
    fill_all(8'h03, 8'h04, -1);
    cycle(0, 0, 0, 1, 0);
    checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL rstp_enter_pending got=%0b exp=0", load_ready); end
    nRESET = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstp_valid got=%0b exp=0", out_valid); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rstp_lr got=%0b exp=1", load_ready); end
    checks++; if (out_thr !== 8'd50) begin errors++; $display("FAIL rstp_thr got=%0d exp=50", out_thr); end
    checks++; if (out_ref !== 8'd0 || out_ring !== '0) begin errors++; $display("FAIL rstp_data got=%h/%h exp=0/0", out_ref, out_ring); end
    model_reset();
    @(negedge clk) nRESET = 1;
    cycle(0, 0, 0, 1, 0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rstp_mask_cleared got=%0b exp=1", err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstp_no_xfer got=%0b exp=0", out_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      bit we, cm, rdy;
      int a;
      logic [7:0] d;
      we  = ($urandom_range(0, 1) == 1);
      a   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, RING_N + 1));
      d   = 8'($urandom);
      cm  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      cycle(we, a, d, cm, rdy);
      checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, out_valid, m_valid); end
      checks++; if (load_ready !== !m_pend) begin errors++; $display("FAIL rnd_load_ready n=%0d got=%0b exp=%0b", n, load_ready, !m_pend); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, err, m_err); end
      checks++; if (out_ref !== m_oref) begin errors++; $display("FAIL rnd_ref n=%0d got=%h exp=%h", n, out_ref, m_oref); end
      checks++; if (out_ring !== m_ring_vec()) begin errors++; $display("FAIL rnd_ring n=%0d got=%h exp=%h", n, out_ring, m_ring_vec()); end
      checks++; if (out_thr !== m_othr) begin errors++; $display("FAIL rnd_thr n=%0d got=%h exp=%h", n, out_thr, m_othr); end
    end
  endtask

  initial begin
    nRESET = 0; wr_en = 0; wr_addr = '0; wr_data = '0; wr_commit = 0; out_ready = 0;
    model_reset();
    test_reset();
    test_basic_window();
    test_incomplete();
    test_back_to_back();
    test_bad_addr();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
